// File: rtl/arm_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the multicycle ARM-subset controller:
//   state_t        FSM state encoding (FETCH .. BRANCH)
//   OP_*           instruction class codes taken from IR[27:26]
//   ALU_*          alu_control codes driven towards the datapath ALU
//   COND_*         condition-field codes taken from IR[31:28]
//   dp_to_alu()    maps a data-processing cmd (IR[24:21]) to an ALU code
//   dp_is_arith()  true for cmds whose C/V flags come from the adder
// ----------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXECR,
        EXECI,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWR,
        MEMWB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_ORR = 4'd3;
    localparam logic [3:0] ALU_EOR = 4'd4;
    localparam logic [3:0] ALU_RSB = 4'd5;
    localparam logic [3:0] ALU_ADC = 4'd6;
    localparam logic [3:0] ALU_SBC = 4'd7;
    localparam logic [3:0] ALU_RSC = 4'd8;
    localparam logic [3:0] ALU_MOV = 4'd9;
    localparam logic [3:0] ALU_BIC = 4'd10;
    localparam logic [3:0] ALU_MVN = 4'd11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // The test/compare cmds reuse the ALU op of their arithmetic twin;
    // the result is simply never written back.
    function automatic logic [3:0] dp_to_alu(input logic [3:0] cmd);
        case (cmd)
            4'b0000: dp_to_alu = ALU_AND;
            4'b0001: dp_to_alu = ALU_EOR;
            4'b0010: dp_to_alu = ALU_SUB;
            4'b0011: dp_to_alu = ALU_RSB;
            4'b0100: dp_to_alu = ALU_ADD;
            4'b0101: dp_to_alu = ALU_ADC;
            4'b0110: dp_to_alu = ALU_SBC;
            4'b0111: dp_to_alu = ALU_RSC;
            4'b1000: dp_to_alu = ALU_AND;
            4'b1001: dp_to_alu = ALU_EOR;
            4'b1010: dp_to_alu = ALU_SUB;
            4'b1011: dp_to_alu = ALU_ADD;
            4'b1100: dp_to_alu = ALU_ORR;
            4'b1101: dp_to_alu = ALU_MOV;
            4'b1110: dp_to_alu = ALU_BIC;
            default: dp_to_alu = ALU_MVN;
        endcase
    endfunction

    // Logical ops leave C and V alone even when S is set.
    function automatic logic dp_is_arith(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010, 4'b1011: dp_is_arith = 1'b1;
            default:                            dp_is_arith = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_check.sv
// ----------------------------------------------------------------------------
// cond_check
// Combinational ARM condition evaluation.
//   cond     in  4  IR[31:28] condition field
//   flags    in  4  stored {N,Z,C,V}
//   cond_ex  out 1  instruction is allowed to execute
// 4'hF is treated as "never" rather than as an unconditional extension space.
// ----------------------------------------------------------------------------
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
// Moore FSM sequencing a shared-memory multicycle ARM-subset datapath through
// fetch / decode / execute / writeback, with an NZCV register and
// conditional-execution gating.
//   clk, rst_n                      clock, async active-low reset
//   op, funct, cond, rd             instruction fields straight from the IR
//   alu_flags                       ALU {N,Z,C,V} of the current cycle
//   mem_ready                       memory finished the current access
//   pc_write, ir_write, reg_write,
//   mem_write                       datapath load/write strobes
//   adr_src, result_src, alu_src_a,
//   alu_src_b, imm_src, reg_src     datapath mux selects
//   alu_control                     ALU operation code
//   flags                           stored NZCV
//   illegal_op                      one-cycle pulse in DECODE for op==3
// ----------------------------------------------------------------------------
module multicycle_control_unit
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W   = 4,
    parameter int COND_EXEC_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            cond,
    input  logic [3:0]            rd,
    input  logic [3:0]            alu_flags,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            flags,
    output logic                  illegal_op
);

    state_t     state, next_state;
    logic [3:0] flags_q;
    logic       cond_pass, cond_ex;
    logic       pc_write_raw, ir_write_raw, reg_write_raw, mem_write_raw, illegal_raw;
    logic [3:0] alu_op;
    logic       in_exec;

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_pass)
    );

    // With conditional execution compiled out every instruction runs.
    assign cond_ex = (COND_EXEC_EN != 0) ? cond_pass : 1'b1;
    assign in_exec = (state == EXECR) || (state == EXECI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // N/Z follow any S-bit instruction; C/V only come from the adder, so
    // logical ops keep the previous carry and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (in_exec && funct[0]) begin
            flags_q[3:2] <= alu_flags[3:2];
            if (dp_is_arith(funct[4:1])) flags_q[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        next_state    = state;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        imm_src       = 2'd0;
        reg_src       = 2'b00;
        alu_op        = ALU_ADD;
        case (state)
            FETCH: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'd2;
                result_src   = 2'd2;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                // ALUOut captures PC+8 here for later R15 reads.
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                if (op == OP_ILL) begin
                    illegal_raw = 1'b1;
                    next_state  = FETCH;
                end else if (!cond_ex) begin
                    next_state = FETCH;
                end else begin
                    case (op)
                        OP_DP:   next_state = funct[5] ? EXECI : EXECR;
                        OP_MEM:  next_state = MEMADR;
                        OP_BR:   next_state = BRANCH;
                        default: next_state = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                alu_src_b  = (state == EXECI) ? 2'd1 : 2'd0;
                alu_op     = dp_to_alu(funct[4:1]);
                // TST/TEQ/CMP/CMN only produce flags.
                next_state = (funct[4:3] == 2'b10) ? FETCH : ALUWB;
            end
            ALUWB: begin
                result_src = 2'd0;
                if (rd == 4'd15) pc_write_raw  = 1'b1;
                else             reg_write_raw = 1'b1;
                next_state = FETCH;
            end
            MEMADR: begin
                alu_src_b  = 2'd1;
                imm_src    = 2'd1;
                alu_op     = funct[3] ? ALU_ADD : ALU_SUB;
                next_state = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWR: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                reg_src       = 2'b10;
                if (mem_ready) next_state = FETCH;
            end
            MEMWB: begin
                result_src = 2'd1;
                if (rd == 4'd15) pc_write_raw  = 1'b1;
                else             reg_write_raw = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                reg_src      = 2'b01;
                alu_src_b    = 2'd1;
                imm_src      = 2'd2;
                result_src   = 2'd2;
                pc_write_raw = 1'b1;
                next_state   = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Strobes are masked by rst_n so nothing is written while reset is held,
    // including the FETCH-state mem_ready pass-through.
    assign pc_write    = pc_write_raw  & rst_n;
    assign ir_write    = ir_write_raw  & rst_n;
    assign reg_write   = reg_write_raw & rst_n;
    assign mem_write   = mem_write_raw & rst_n;
    assign illegal_op  = illegal_raw   & rst_n;
    assign alu_control = ALU_CTRL_W'(alu_op);
    assign flags       = flags_q;

endmodule
